// File: rtl/riscv_int_controller_mc.sv
// Multi-line fixed-priority interrupt controller feeding the ID-stage req/ack/kill handshake.
// Optional per-line rising-edge capture is enabled by defining RISCV_IRQ_EDGE_EN.
module riscv_int_controller_mc #(
    parameter int NUM_IRQ     = 32,
    parameter int PULP_SECURE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_sec_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    input  logic [NUM_IRQ-1:0] irq_edge_i,
    input  logic               m_IE_i,
    input  logic               u_IE_i,
    input  logic [1:0]         current_priv_lvl_i,
    input  logic               ctrl_ack_i,
    input  logic               ctrl_kill_i,
    output logic               irq_req_ctrl_o,
    output logic               irq_sec_ctrl_o,
    output logic [4:0]         irq_id_ctrl_o,
    output logic               irq_ack_o,
    output logic [4:0]         irq_ack_id_o,
    output logic [NUM_IRQ-1:0] irq_pending_o
);

    localparam logic [1:0] PRIV_LVL_M = 2'b11;
    localparam logic [1:0] PRIV_LVL_U = 2'b00;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_DONE    = 2'd2
    } irq_state_e;

    irq_state_e         state_q;
    logic [4:0]         id_q;
    logic               sec_q;
    logic               ack_q;
    logic [4:0]         ack_id_q;

    logic [NUM_IRQ-1:0] eff;
    logic [NUM_IRQ-1:0] cand;
    logic [4:0]         sel_id;
    logic               sel_sec;
    logic               glb_en;

`ifdef RISCV_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;

    // A fresh edge beats the completion clear so back-to-back edges are never dropped.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
        assign rise[gi]   = irq_i[gi] & ~irq_q[gi] & irq_edge_i[gi];
        assign clr[gi]    = (state_q == IRQ_DONE) && (id_q == 5'(gi)) && irq_edge_i[gi];
        assign pend_d[gi] = rise[gi] | (pend_q[gi] & ~clr[gi]);
        assign eff[gi]    = irq_edge_i[gi] ? (pend_q[gi] | (irq_i[gi] & ~irq_q[gi]))
                                           : irq_i[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= irq_i;
            pend_q <= pend_d;
        end
    end
`else
    logic [NUM_IRQ-1:0] unused_irq_edge;
    assign unused_irq_edge = irq_edge_i;
    assign eff             = irq_i;
`endif

    assign cand = eff & irq_mask_i;

    always_comb begin
        sel_id  = 5'd0;
        sel_sec = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand[i]) begin
                sel_id  = 5'(i);
                sel_sec = irq_sec_i[i];
            end
        end
    end

    // In U-mode a secure line is allowed through even with u_IE cleared.
    always_comb begin
        if (PULP_SECURE != 0) begin
            glb_en = ((u_IE_i | sel_sec) && (current_priv_lvl_i == PRIV_LVL_U)) ||
                     (m_IE_i && (current_priv_lvl_i == PRIV_LVL_M));
        end else begin
            glb_en = m_IE_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= 5'd0;
            sec_q    <= 1'b0;
            ack_q    <= 1'b0;
            ack_id_q <= 5'd0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (glb_en && (|cand)) begin
                        state_q <= IRQ_PENDING;
                        id_q    <= sel_id;
                        sec_q   <= sel_sec;
                    end
                end
                IRQ_PENDING: begin
                    if (ctrl_ack_i) begin
                        state_q  <= IRQ_DONE;
                        ack_q    <= 1'b1;
                        ack_id_q <= id_q;
                    end else if (ctrl_kill_i) begin
                        state_q <= IDLE;
                    end
                end
                IRQ_DONE: begin
                    state_q <= IDLE;
                    sec_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_req_ctrl_o = (state_q == IRQ_PENDING);
    assign irq_sec_ctrl_o = sec_q;
    assign irq_id_ctrl_o  = id_q;
    assign irq_ack_o      = ack_q;
    assign irq_ack_id_o   = ack_id_q;
    assign irq_pending_o  = eff;

endmodule

// File: tb/tb_riscv_int_controller_mc.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_riscv_int_controller_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irq = '0, irq_sec = '0, irq_mask = '0, irq_edge = '0;
    logic        m_IE = 1'b0, u_IE = 1'b0;
    logic [1:0]  priv = 2'b11;
    logic        ack = 1'b0, kill = 1'b0;

    logic        req_o, sec_o, ack_o;
    logic [4:0]  id_o, ack_id_o;
    logic [31:0] pend_o;

    int n_checks = 0;
    int n_errors = 0;

    riscv_int_controller_mc #(.NUM_IRQ(32), .PULP_SECURE(1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .irq_i              (irq),
        .irq_sec_i          (irq_sec),
        .irq_mask_i         (irq_mask),
        .irq_edge_i         (irq_edge),
        .m_IE_i             (m_IE),
        .u_IE_i             (u_IE),
        .current_priv_lvl_i (priv),
        .ctrl_ack_i         (ack),
        .ctrl_kill_i        (kill),
        .irq_req_ctrl_o     (req_o),
        .irq_sec_ctrl_o     (sec_o),
        .irq_id_ctrl_o      (id_o),
        .irq_ack_o          (ack_o),
        .irq_ack_id_o       (ack_id_o),
        .irq_pending_o      (pend_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase = 0;   // 0 waiting, 1 request shown, 2 completing
    logic [4:0]  m_id = '0, m_ack_id = '0;
    logic        m_sec = 1'b0, m_ack = 1'b0;
    logic [31:0] m_pend = '0, m_prev = '0;

    function automatic logic [31:0] model_eff();
        logic [31:0] e;
        e = irq;
`ifdef RISCV_IRQ_EDGE_EN
        for (int i = 0; i < 32; i++)
            if (irq_edge[i]) e[i] = m_pend[i] | (irq[i] & ~m_prev[i]);
`endif
        return e;
    endfunction

    function automatic logic model_enable(input logic s);
        if (priv == 2'b11) return m_IE;
        if (priv == 2'b00) return u_IE | s;
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0; m_id = '0; m_sec = 1'b0; m_ack = 1'b0; m_ack_id = '0;
            m_pend = '0; m_prev = '0;
        end else begin
            logic [31:0] c, np;
            int w;
            c = model_eff() & irq_mask;
            w = -1;
            for (int i = 0; i < 32; i++) if (c[i]) w = i;
            np = m_pend;
`ifdef RISCV_IRQ_EDGE_EN
            if (m_phase == 2 && irq_edge[m_id]) np[m_id] = 1'b0;
            for (int i = 0; i < 32; i++)
                if (irq_edge[i] && irq[i] && !m_prev[i]) np[i] = 1'b1;
`endif
            m_ack = 1'b0;
            case (m_phase)
                0: if (w >= 0 && model_enable(irq_sec[w])) begin
                       m_phase = 1; m_id = 5'(w); m_sec = irq_sec[w];
                   end
                1: if (ack) begin
                       m_phase = 2; m_ack = 1'b1; m_ack_id = m_id;
                   end else if (kill) m_phase = 0;
                default: begin m_phase = 0; m_sec = 1'b0; end
            endcase
            m_pend = np;
            m_prev = irq;
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("req", req_o, m_phase == 1);
            chk("sec", sec_o, m_sec);
            chk("id", id_o, m_id);
            chk("ack", ack_o, m_ack);
            if (m_ack) chk("ack_id", ack_id_o, m_ack_id);
            chk("pending", pend_o, model_eff());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick(); tick();
        chk("rst_req", req_o, 0);
        chk("rst_sec", sec_o, 0);
        chk("rst_id", id_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_ack_id", ack_id_o, 0);
        rst_n = 1'b1; irq_mask = '1; m_IE = 1'b1; priv = 2'b11;
        tick();

        // Level priority: 17 beats 3, then 3 follows after the ack.
        irq[3] = 1'b1; irq[17] = 1'b1;
        tick();
        chk("lvl_req", req_o, 1); chk("lvl_id17", id_o, 17);
        ack = 1'b1; irq[17] = 1'b0;
        tick();
        chk("lvl_req_drop", req_o, 0); chk("lvl_ack", ack_o, 1); chk("lvl_ack_id17", ack_id_o, 17);
        ack = 1'b0;
        tick();
        chk("lvl_idle", req_o, 0);
        tick();
        chk("lvl_req3", req_o, 1); chk("lvl_id3", id_o, 3);
        ack = 1'b1; irq[3] = 1'b0;
        tick(); ack = 1'b0; tick(); tick();

        // Global enable gating.
        m_IE = 1'b0; irq[5] = 1'b1;
        tick(); tick();
        chk("gate_noreq", req_o, 0);
        m_IE = 1'b1;
        tick();
        chk("gate_req", req_o, 1); chk("gate_id5", id_o, 5);
        ack = 1'b1; irq[5] = 1'b0;
        tick(); ack = 1'b0; tick(); tick();

        // Kill then re-request; simultaneous ack and kill completes.
        irq[12] = 1'b1;
        tick();
        chk("kill_req", req_o, 1); chk("kill_id12", id_o, 12);
        kill = 1'b1;
        tick();
        chk("kill_drop", req_o, 0); chk("kill_noack", ack_o, 0);
        kill = 1'b0;
        tick();
        chk("kill_rereq", req_o, 1); chk("kill_reid", id_o, 12);
        ack = 1'b1; kill = 1'b1;
        tick();
        chk("ackkill_ack", ack_o, 1); chk("ackkill_id", ack_id_o, 12); chk("ackkill_req", req_o, 0);
        ack = 1'b0; kill = 1'b0; irq[12] = 1'b0;
        tick(); tick();

`ifdef RISCV_IRQ_EDGE_EN
        // Edge captured while masked, taken once unmasked, cleared on completion.
        irq_edge = 32'h0000_0200; irq_mask[9] = 1'b0; irq[9] = 1'b1;
        tick();
        irq[9] = 1'b0; #1;
        chk("edge_pend", pend_o[9], 1);
        tick(); tick();
        chk("edge_masked_noreq", req_o, 0);
        irq_mask[9] = 1'b1;
        tick();
        chk("edge_req", req_o, 1); chk("edge_id9", id_o, 9);
        ack = 1'b1;
        tick(); ack = 1'b0;
        tick(); #1;
        chk("edge_cleared", pend_o[9], 0);
        // New edge arriving in the completing cycle survives the clear.
        irq[9] = 1'b1;
        tick();
        chk("coll_req1", req_o, 1);
        irq[9] = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0; irq[9] = 1'b1;
        tick(); #1;
        chk("coll_pend", pend_o[9], 1);
        tick();
        chk("coll_req2", req_o, 1); chk("coll_id9", id_o, 9);
        ack = 1'b1; irq[9] = 1'b0;
        tick(); ack = 1'b0; tick(); tick();
        irq_edge = '0;
`endif

        // Secure gating in U-mode, then asynchronous reset while pending.
        priv = 2'b00; u_IE = 1'b0; irq_sec = 32'h0000_0010; irq[4] = 1'b1;
        tick();
        chk("sec_req", req_o, 1); chk("sec_id4", id_o, 4); chk("sec_bit", sec_o, 1);
        ack = 1'b1; irq[4] = 1'b0;
        tick(); ack = 1'b0; tick(); tick();
        chk("sec_cleared", sec_o, 0);
        irq[6] = 1'b1;
        tick(); tick(); tick();
        chk("nonsec_noreq", req_o, 0);
        irq[6] = 1'b0; irq[4] = 1'b1;
        tick();
        chk("sec_req2", req_o, 1);
        rst_n = 1'b0; #1;
        chk("arst_req", req_o, 0); chk("arst_sec", sec_o, 0); chk("arst_id", id_o, 0);
        chk("arst_ack", ack_o, 0); chk("arst_ack_id", ack_id_o, 0);
        irq[4] = 1'b0;
        tick();
        rst_n = 1'b1; priv = 2'b11; irq_sec = '0;
        tick();

        // Randomized traffic checked by the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) begin
                irq_edge = $urandom;
                irq_sec  = $urandom;
            end
            irq = irq ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) irq_mask = $urandom & $urandom;
            if ($urandom_range(0, 7) == 0) begin
                m_IE = 1'($urandom_range(0, 1));
                u_IE = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0: priv = 2'b00;
                    1: priv = 2'b01;
                    default: priv = 2'b11;
                endcase
            end
            ack  = ($urandom_range(0, 3) == 0);
            kill = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
